// File: rtl/window_expiry_reader.sv
// Consumer side of the time-tracking queue. It pops the queue head once the
// head has waited WINDOW cycles, keeps a running window sum and element count,
// and reports each expired element as a one-cycle pulse.
module window_expiry_reader #(
  parameter int DATA_W      = 64,
  parameter int AGE_W       = 64,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ev_valid,
  input  logic signed [DATA_W-1:0] ev_data,
  input  logic                     head_valid,
  input  logic [AGE_W-1:0]         head_age,
  output logic                     pop,
  input  logic                     pop_valid,
  input  logic signed [DATA_W-1:0] out,
  input  logic [AGE_W-1:0]         waited,
  output logic signed [DATA_W-1:0] win_sum,
  output logic [CNT_W-1:0]         win_count,
  output logic                     expired_valid,
  output logic signed [DATA_W-1:0] expired_data,
  output logic [AGE_W-1:0]         expired_age,
  output logic                     err
);

  // The wait timer only needs to count the WAIT cycles 0..ACK_TIMEOUT-1.
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COOL
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout;
  logic             spurious_ack;
  logic             count_underflow;
  logic             count_overflow;

  // Next-state, pop request and ack-timeout detection for the pop handshake.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    pop     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_valid && (head_age >= AGE_LIMIT)) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (pop_valid) begin
          state_d = COOL;
        end else if (timer_q == TMR_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!en || !rst) begin
      pop = 1'b0;
    end
  end

  // Error conditions that are judged on the current cycle's inputs.
  always_comb begin
    spurious_ack    = pop_valid && (state_q != WAIT);
    count_underflow = pop_valid && (win_count == '0);
    count_overflow  = ev_valid && (win_count == CNT_MAX);
  end

  // Handshake state register; reset drops any outstanding pop silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Window sum/count bookkeeping; count saturates at both ends, sum wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_sum   <= '0;
      win_count <= '0;
    end else if (en) begin
      case ({ev_valid, pop_valid})
        2'b10: begin
          win_sum <= win_sum + ev_data;
          if (win_count != CNT_MAX) begin
            win_count <= win_count + 1'b1;
          end
        end
        2'b01: begin
          win_sum <= win_sum - out;
          if (win_count != '0) begin
            win_count <= win_count - 1'b1;
          end
        end
        2'b11: begin
          win_sum <= win_sum + ev_data - out;
        end
        default: begin
          win_sum <= win_sum;
        end
      endcase
    end
  end

  // Expired-element report follows every completed pop, whatever the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      expired_valid <= 1'b0;
      expired_data  <= '0;
      expired_age   <= '0;
    end else if (en) begin
      expired_valid <= pop_valid;
      if (pop_valid) begin
        expired_data <= out;
        expired_age  <= waited;
      end
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (en) begin
      if (timeout || spurious_ack || count_underflow || count_overflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule
